mips_multicycle_control: RTL and testbench
==========================================

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 The block SHALL use one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 op_code  in  6  instruction register bits [31:26]; sampled in DECODE.
REQ-005 funct  in  6  instruction register bits [5:0]; sampled in DECODE.
REQ-006 zero  in  1  ALU zero flag, used in BRANCH only.
REQ-007 mem_ready  in  1  memory done/grant for the current read or write access.
REQ-008 pc_write  out  1  load PC. ir_write  out  1  load IR. i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 mem_read, mem_write, reg_write  out  1 each  strobes.
REQ-010 reg_dst  out  2  00 = rt, 11 = rd, 01 = R[31]. mem_to_reg  out  2  00 = ALUOut, 01 = PC, 11 = MDR.
REQ-011 alu_src_a  out  1  0 = PC, 1 = A. alu_src_b  out  2  00 = B, 01 = const 4, 10 = sext(imm), 11 = sext(imm)<<2.
REQ-012 alu_op  out  4  ALU encodings: AND 0000, OR 0001, NOR 0010, none 0011, ADD 0100, ADDU 0101, SUB 0110, SUBU 0111, SLL 1000, SRL 1010, LUI 1100, SLT 1110, SLTU 1111.
REQ-013 pc_source  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump address, 11 = R[rs].
REQ-014 byte_number  out  2  00 = word, 01 = half, 10 = byte.
REQ-015 state  out  4  current state. illegal  out  1  one-cycle pulse on an undecodable instruction. instr_count  out  32  retired-instruction count.

Function
REQ-016 The state encoding SHALL be: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11, JR 12. Codes 13-15 SHALL go to FETCH.
REQ-017 Outputs SHALL decode from the state and the latched op_code/funct. Any output not listed for a state SHALL be 0.
REQ-018 FETCH: mem_read=1, alu_src_b=01, alu_op=0100, ir_write=pc_write=mem_ready. Stay while mem_ready=0. Go to DECODE when mem_ready=1.
REQ-019 DECODE: latch op_code/funct, alu_src_b=11, alu_op=0100. Next state:
  - R with funct 001000 -> JR; other valid R funct -> R_EXEC.
  - 000010/000011 -> JUMP.
  - 000100/000101 -> BRANCH.
  - loads 100011, 110000, 100100, 100101 -> MEM_ADDR; stores 101011, 111000, 101000, 101001 -> MEM_ADDR.
  - 001111, 001000, 001001, 001100, 001101, 001010, 001011 -> I_EXEC.
  - anything else -> FETCH with illegal=1.
REQ-020 Valid R funct codes SHALL map to alu_op as: 100000->0100, 100001->0101, 100100->0000, 100111->0010, 100101->0001, 101010->1110, 101011->1111, 000000->1000, 000010->1010, 100010->0110, 100011->0111.
REQ-021 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=0100. Go to MEM_READ for loads and MEM_WRITE for stores.
REQ-022 byte_number SHALL be held in MEM_ADDR/MEM_READ/MEM_WB/MEM_WRITE: 100100, 101000 -> 10; 100101, 101001 -> 01; otherwise 00.
REQ-023 MEM_READ: mem_read=1, i_or_d=1. Wait for mem_ready, then go to MEM_WB.
REQ-024 MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=11, then go to FETCH.
REQ-025 MEM_WRITE: mem_write=1, i_or_d=1. Wait for mem_ready, then go to FETCH.
REQ-026 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op per REQ-020, then go to R_WB.
REQ-027 R_WB: reg_write=1, reg_dst=11, mem_to_reg=00, then go to FETCH.
REQ-028 I_EXEC: alu_src_a=1, alu_src_b=10. alu_op SHALL be: ADDI 0100, ADDIU 0101, ANDI 0000, ORI 0001, SLTI 1110, SLTIU 1111, LUI 1100. Then go to I_WB.
REQ-029 I_WB: reg_write=1, reg_dst=00, mem_to_reg=00, then go to FETCH.
REQ-030 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=0110, pc_source=01. pc_write SHALL equal zero for BEQ and ~zero for BNE, combinationally in that cycle. Then go to FETCH.
REQ-031 JUMP: pc_source=10, pc_write=1. For JAL also reg_write=1, reg_dst=01, mem_to_reg=01. Then go to FETCH.
REQ-032 JR: pc_source=11, pc_write=1, alu_op=0011, then go to FETCH.
REQ-033 instr_count SHALL increment by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH, JUMP or JR. It SHALL wrap from FFFFFFFF to 0. An illegal instruction SHALL NOT increment it.
REQ-034 mem_ready SHALL be ignored in all states except FETCH, MEM_READ and MEM_WRITE.

Reset
REQ-035 While rst_n=0, in any state including mid-access, the block SHALL force state=FETCH, instr_count=0, latched op_code/funct=0 and illegal=0.
REQ-036 After reset, FETCH outputs SHALL apply. No register or memory write SHALL occur until a new FETCH with mem_ready=1.

Verification
REQ-037 Reset during MEM_READ with mem_ready=0 -> state=0, instr_count=0, mem_write=reg_write=0.
REQ-038 ADD (op 000000, funct 100000), mem_ready=1 -> states 0,1,6,7,0; alu_op=0100 in R_EXEC; reg_write=1 and reg_dst=11 in R_WB; instr_count +1.
REQ-039 LHU (100101) with mem_ready low for 3 cycles in MEM_READ -> state stays 3 for 4 cycles with mem_read=1, i_or_d=1, byte_number=01; then MEM_WB with mem_to_reg=11.
REQ-040 BEQ with zero=0 -> pc_write=0 in BRANCH; BNE with zero=0 -> pc_write=1, pc_source=01.
REQ-041 JAL (000011) -> JUMP with pc_write=1, pc_source=10, reg_write=1, reg_dst=01, mem_to_reg=01. JR (funct 001000) -> JR state with pc_source=11, reg_write=0.
REQ-042 Opcode 111111 -> illegal=1 for one cycle in DECODE, then FETCH; instr_count unchanged; no write strobes.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS control FSM with retired-instruction counter
// op_code/funct are latched on the DECODE edge; later states decode from the latched copy.
module mips_multicycle_control (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [5:0]  i_op_code,
   input  logic [5:0]  i_funct,
   input  logic        i_zero,
   input  logic        i_mem_ready,
   output logic        o_pc_write,
   output logic        o_ir_write,
   output logic        o_i_or_d,
   output logic        o_mem_read,
   output logic        o_mem_write,
   output logic        o_reg_write,
   output logic [1:0]  o_reg_dst,
   output logic [1:0]  o_mem_to_reg,
   output logic        o_alu_src_a,
   output logic [1:0]  o_alu_src_b,
   output logic [3:0]  o_alu_op,
   output logic [1:0]  o_pc_source,
   output logic [1:0]  o_byte_number,
   output logic [3:0]  o_state,
   output logic        o_illegal,
   output logic [31:0] o_instr_count
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_I_EXEC    = 4'd8,
      S_I_WB      = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11,
      S_JR        = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] F_JR     = 6'b001000;
   localparam logic [3:0] ALU_ADD  = 4'b0100;

   state_t      r_state;
   state_t      w_next;
   logic [5:0]  r_op_code;
   logic [5:0]  r_funct;
   logic [31:0] r_instr_count;
   logic [4:0]  w_live_r;
   logic [4:0]  w_live_i;
   logic [4:0]  w_exec_r;
   logic [4:0]  w_exec_i;
   logic        w_retire;

   // Returns {valid, alu_op} for an R-type funct field.
   function automatic logic [4:0] f_r_decode(input logic [5:0] fn);
      case (fn)
         6'b100000: return {1'b1, 4'b0100};
         6'b100001: return {1'b1, 4'b0101};
         6'b100100: return {1'b1, 4'b0000};
         6'b100111: return {1'b1, 4'b0010};
         6'b100101: return {1'b1, 4'b0001};
         6'b101010: return {1'b1, 4'b1110};
         6'b101011: return {1'b1, 4'b1111};
         6'b000000: return {1'b1, 4'b1000};
         6'b000010: return {1'b1, 4'b1010};
         6'b100010: return {1'b1, 4'b0110};
         6'b100011: return {1'b1, 4'b0111};
         default:   return {1'b0, 4'b0011};
      endcase
   endfunction

   function automatic logic [4:0] f_i_decode(input logic [5:0] op);
      case (op)
         6'b001000: return {1'b1, 4'b0100};
         6'b001001: return {1'b1, 4'b0101};
         6'b001100: return {1'b1, 4'b0000};
         6'b001101: return {1'b1, 4'b0001};
         6'b001010: return {1'b1, 4'b1110};
         6'b001011: return {1'b1, 4'b1111};
         6'b001111: return {1'b1, 4'b1100};
         default:   return {1'b0, 4'b0011};
      endcase
   endfunction

   function automatic logic f_is_load(input logic [5:0] op);
      return (op == 6'b100011) || (op == 6'b110000) || (op == 6'b100100) || (op == 6'b100101);
   endfunction

   function automatic logic f_is_store(input logic [5:0] op);
      return (op == 6'b101011) || (op == 6'b111000) || (op == 6'b101000) || (op == 6'b101001);
   endfunction

   function automatic logic [1:0] f_byte_number(input logic [5:0] op);
      case (op)
         6'b100100, 6'b101000: return 2'b10;
         6'b100101, 6'b101001: return 2'b01;
         default:              return 2'b00;
      endcase
   endfunction

   assign w_live_r = f_r_decode(i_funct);
   assign w_live_i = f_i_decode(i_op_code);
   assign w_exec_r = f_r_decode(r_funct);
   assign w_exec_i = f_i_decode(r_op_code);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_FETCH;
         r_op_code     <= 6'd0;
         r_funct       <= 6'd0;
         r_instr_count <= 32'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_op_code <= i_op_code;
            r_funct   <= i_funct;
         end
         if (w_retire)
            r_instr_count <= r_instr_count + 32'd1;
      end
   end

   always_comb begin
      w_next        = S_FETCH;
      o_pc_write    = 1'b0;
      o_ir_write    = 1'b0;
      o_i_or_d      = 1'b0;
      o_mem_read    = 1'b0;
      o_mem_write   = 1'b0;
      o_reg_write   = 1'b0;
      o_reg_dst     = 2'b00;
      o_mem_to_reg  = 2'b00;
      o_alu_src_a   = 1'b0;
      o_alu_src_b   = 2'b00;
      o_alu_op      = 4'b0000;
      o_pc_source   = 2'b00;
      o_byte_number = 2'b00;
      o_illegal     = 1'b0;
      case (r_state)
         S_FETCH: begin
            o_mem_read  = 1'b1;
            o_alu_src_b = 2'b01;
            o_alu_op    = ALU_ADD;
            o_ir_write  = i_mem_ready;
            o_pc_write  = i_mem_ready;
            w_next      = i_mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            o_alu_src_b = 2'b11;
            o_alu_op    = ALU_ADD;
            if (i_op_code == OP_RTYPE) begin
               if (i_funct == F_JR)
                  w_next = S_JR;
               else if (w_live_r[4])
                  w_next = S_R_EXEC;
               else
                  o_illegal = 1'b1;
            end else if ((i_op_code == OP_J) || (i_op_code == OP_JAL)) begin
               w_next = S_JUMP;
            end else if ((i_op_code == OP_BEQ) || (i_op_code == OP_BNE)) begin
               w_next = S_BRANCH;
            end else if (f_is_load(i_op_code) || f_is_store(i_op_code)) begin
               w_next = S_MEM_ADDR;
            end else if (w_live_i[4]) begin
               w_next = S_I_EXEC;
            end else begin
               o_illegal = 1'b1;
            end
         end
         S_MEM_ADDR: begin
            o_alu_src_a   = 1'b1;
            o_alu_src_b   = 2'b10;
            o_alu_op      = ALU_ADD;
            o_byte_number = f_byte_number(r_op_code);
            w_next        = f_is_load(r_op_code) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            o_mem_read    = 1'b1;
            o_i_or_d      = 1'b1;
            o_byte_number = f_byte_number(r_op_code);
            w_next        = i_mem_ready ? S_MEM_WB : S_MEM_READ;
         end
         S_MEM_WB: begin
            o_reg_write   = 1'b1;
            o_mem_to_reg  = 2'b11;
            o_byte_number = f_byte_number(r_op_code);
         end
         S_MEM_WRITE: begin
            o_mem_write   = 1'b1;
            o_i_or_d      = 1'b1;
            o_byte_number = f_byte_number(r_op_code);
            w_next        = i_mem_ready ? S_FETCH : S_MEM_WRITE;
         end
         S_R_EXEC: begin
            o_alu_src_a = 1'b1;
            o_alu_op    = w_exec_r[3:0];
            w_next      = S_R_WB;
         end
         S_R_WB: begin
            o_reg_write = 1'b1;
            o_reg_dst   = 2'b11;
         end
         S_I_EXEC: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = 2'b10;
            o_alu_op    = w_exec_i[3:0];
            w_next      = S_I_WB;
         end
         S_I_WB: begin
            o_reg_write = 1'b1;
         end
         S_BRANCH: begin
            o_alu_src_a = 1'b1;
            o_alu_op    = 4'b0110;
            o_pc_source = 2'b01;
            o_pc_write  = (r_op_code == OP_BNE) ? ~i_zero : i_zero;
         end
         S_JUMP: begin
            o_pc_source = 2'b10;
            o_pc_write  = 1'b1;
            if (r_op_code == OP_JAL) begin
               o_reg_write  = 1'b1;
               o_reg_dst    = 2'b01;
               o_mem_to_reg = 2'b01;
            end
         end
         S_JR: begin
            o_pc_source = 2'b11;
            o_pc_write  = 1'b1;
            o_alu_op    = 4'b0011;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Illegal decodes and unused state codes return to FETCH without retiring.
   assign w_retire = (w_next == S_FETCH) &&
                     ((r_state == S_MEM_WB) || (r_state == S_MEM_WRITE) || (r_state == S_R_WB) ||
                      (r_state == S_I_WB)   || (r_state == S_BRANCH)    || (r_state == S_JUMP) ||
                      (r_state == S_JR));

   assign o_state       = r_state;
   assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - table, hand-sequence and random checks of mips_multicycle_control
// Expected outputs come from an instruction-level model that expands each instruction into its cycles.
module tb_mips_multicycle_control;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  op_code = 6'd0;
   logic [5:0]  funct = 6'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
   logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source, byte_number;
   logic        alu_src_a, illegal;
   logic [3:0]  alu_op, state;
   logic [31:0] instr_count;

   mips_multicycle_control dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_op_code(op_code), .i_funct(funct),
      .i_zero(zero), .i_mem_ready(mem_ready),
      .o_pc_write(pc_write), .o_ir_write(ir_write), .o_i_or_d(i_or_d),
      .o_mem_read(mem_read), .o_mem_write(mem_write), .o_reg_write(reg_write),
      .o_reg_dst(reg_dst), .o_mem_to_reg(mem_to_reg), .o_alu_src_a(alu_src_a),
      .o_alu_src_b(alu_src_b), .o_alu_op(alu_op), .o_pc_source(pc_source),
      .o_byte_number(byte_number), .o_state(state), .o_illegal(illegal),
      .o_instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
      logic [1:0] reg_dst, mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_op;
      logic [1:0] pc_source, byte_number;
      logic [3:0] state;
      logic       illegal;
   } outs_t;

   typedef struct { logic mr; logic zr; logic [5:0] op; logic [5:0] fn; outs_t e; } step_t;
   typedef struct { logic [5:0] op; logic [5:0] fn; logic z; int fs; int ms; logic [23:0] path; } vec_t;

   localparam int C_R = 0, C_JR = 1, C_J = 2, C_JAL = 3, C_BEQ = 4, C_BNE = 5,
                  C_LD = 6, C_ST = 7, C_IMM = 8, C_ILL = 9;

   outs_t       act;
   step_t       q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_cnt = 32'd0;

   assign act = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
                 alu_src_a, alu_src_b, alu_op, pc_source, byte_number, state, illegal};

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, got, want);
      end
   endtask

   function automatic logic [4:0] r_tab(input logic [5:0] fn);
      case (fn)
         6'b100000: return {1'b1, 4'b0100};
         6'b100001: return {1'b1, 4'b0101};
         6'b100100: return {1'b1, 4'b0000};
         6'b100111: return {1'b1, 4'b0010};
         6'b100101: return {1'b1, 4'b0001};
         6'b101010: return {1'b1, 4'b1110};
         6'b101011: return {1'b1, 4'b1111};
         6'b000000: return {1'b1, 4'b1000};
         6'b000010: return {1'b1, 4'b1010};
         6'b100010: return {1'b1, 4'b0110};
         6'b100011: return {1'b1, 4'b0111};
         default:   return 5'd0;
      endcase
   endfunction

   function automatic logic [4:0] i_tab(input logic [5:0] op);
      case (op)
         6'b001000: return {1'b1, 4'b0100};
         6'b001001: return {1'b1, 4'b0101};
         6'b001100: return {1'b1, 4'b0000};
         6'b001101: return {1'b1, 4'b0001};
         6'b001010: return {1'b1, 4'b1110};
         6'b001011: return {1'b1, 4'b1111};
         6'b001111: return {1'b1, 4'b1100};
         default:   return 5'd0;
      endcase
   endfunction

   function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
      logic [4:0] t;
      if (op == 6'd0) begin
         t = r_tab(fn);
         if (fn == 6'b001000) return C_JR;
         return t[4] ? C_R : C_ILL;
      end
      case (op)
         6'b000010: return C_J;
         6'b000011: return C_JAL;
         6'b000100: return C_BEQ;
         6'b000101: return C_BNE;
         6'b100011, 6'b110000, 6'b100100, 6'b100101: return C_LD;
         6'b101011, 6'b111000, 6'b101000, 6'b101001: return C_ST;
         default: begin
            t = i_tab(op);
            return t[4] ? C_IMM : C_ILL;
         end
      endcase
   endfunction

   function automatic logic [1:0] bn(input logic [5:0] op);
      if (op == 6'b100100 || op == 6'b101000) return 2'b10;
      if (op == 6'b100101 || op == 6'b101001) return 2'b01;
      return 2'b00;
   endfunction

   // Off-path inputs are randomised: the block must ignore them outside the states that use them.
   task automatic put(input logic mr, input logic zr, input logic [5:0] op, input logic [5:0] fn, input outs_t e);
      step_t s;
      s.mr = mr; s.zr = zr; s.op = op; s.fn = fn; s.e = e;
      q.push_back(s);
   endtask

   function automatic logic r1();
      return 1'($urandom);
   endfunction

   function automatic logic [5:0] r6();
      return 6'($urandom);
   endfunction

   task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input int fs, input int ms, output int c);
      outs_t o;
      logic [4:0] t;
      c = cls(op, fn);
      for (int i = 0; i <= fs; i++) begin
         o = '0; o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_op = 4'b0100;
         o.pc_write = (i == fs); o.ir_write = (i == fs);
         put(i == fs, r1(), r6(), r6(), o);
      end
      o = '0; o.state = 4'd1; o.alu_src_b = 2'b11; o.alu_op = 4'b0100; o.illegal = (c == C_ILL);
      put(r1(), r1(), op, fn, o);
      case (c)
         C_R: begin
            t = r_tab(fn);
            o = '0; o.state = 4'd6; o.alu_src_a = 1'b1; o.alu_op = t[3:0]; put(r1(), r1(), r6(), r6(), o);
            o = '0; o.state = 4'd7; o.reg_write = 1'b1; o.reg_dst = 2'b11; put(r1(), r1(), r6(), r6(), o);
         end
         C_JR: begin
            o = '0; o.state = 4'd12; o.pc_source = 2'b11; o.pc_write = 1'b1; o.alu_op = 4'b0011;
            put(r1(), r1(), r6(), r6(), o);
         end
         C_J, C_JAL: begin
            o = '0; o.state = 4'd11; o.pc_source = 2'b10; o.pc_write = 1'b1;
            if (c == C_JAL) begin o.reg_write = 1'b1; o.reg_dst = 2'b01; o.mem_to_reg = 2'b01; end
            put(r1(), r1(), r6(), r6(), o);
         end
         C_BEQ, C_BNE: begin
            o = '0; o.state = 4'd10; o.alu_src_a = 1'b1; o.alu_op = 4'b0110; o.pc_source = 2'b01;
            o.pc_write = (c == C_BEQ) ? z : ~z;
            put(r1(), z, r6(), r6(), o);
         end
         C_LD, C_ST: begin
            o = '0; o.state = 4'd2; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 4'b0100;
            o.byte_number = bn(op);
            put(r1(), r1(), r6(), r6(), o);
            for (int i = 0; i <= ms; i++) begin
               o = '0; o.i_or_d = 1'b1; o.byte_number = bn(op);
               if (c == C_LD) begin o.state = 4'd3; o.mem_read = 1'b1; end
               else begin o.state = 4'd5; o.mem_write = 1'b1; end
               put(i == ms, r1(), r6(), r6(), o);
            end
            if (c == C_LD) begin
               o = '0; o.state = 4'd4; o.reg_write = 1'b1; o.mem_to_reg = 2'b11; o.byte_number = bn(op);
               put(r1(), r1(), r6(), r6(), o);
            end
         end
         C_IMM: begin
            t = i_tab(op);
            o = '0; o.state = 4'd8; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = t[3:0];
            put(r1(), r1(), r6(), r6(), o);
            o = '0; o.state = 4'd9; o.reg_write = 1'b1; put(r1(), r1(), r6(), r6(), o);
         end
         default: ;
      endcase
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fs, input int ms, output logic [23:0] seen);
      step_t s;
      int c;
      logic [3:0] prev;
      prev = 4'hF;
      seen = 24'd0;
      build(op, fn, z, fs, ms, c);
      while (q.size() > 0) begin
         s = q.pop_front();
         @(negedge clk);
         mem_ready = s.mr; zero = s.zr; op_code = s.op; funct = s.fn;
         #1;
         chk("outputs", 32'(act), 32'(s.e));
         chk("instr_count", instr_count, exp_cnt);
         if (state != prev) begin
            seen = {seen[19:0], state};
            prev = state;
         end
      end
      if (c != C_ILL) exp_cnt = exp_cnt + 32'd1;
   endtask

   vec_t        vt[16];
   logic [23:0] seen;
   logic [5:0]  ops[22] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h30, 6'h24, 6'h25,
                            6'h2B, 6'h38, 6'h28, 6'h29, 6'h0F, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0B};
   logic [5:0]  fns[12] = '{6'h20, 6'h21, 6'h24, 6'h27, 6'h25, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h22, 6'h23, 6'h08};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [5:0] rop, rfn;
      vt[0]  = '{6'b000000, 6'b100000, 1'b0, 0, 0, 24'h0167};
      vt[1]  = '{6'b100101, 6'b000000, 1'b0, 1, 3, 24'h01234};
      vt[2]  = '{6'b000100, 6'b000000, 1'b0, 0, 0, 24'h01A};
      vt[3]  = '{6'b000101, 6'b000000, 1'b0, 0, 0, 24'h01A};
      vt[4]  = '{6'b000011, 6'b000000, 1'b0, 0, 0, 24'h01B};
      vt[5]  = '{6'b000000, 6'b001000, 1'b1, 0, 0, 24'h01C};
      vt[6]  = '{6'b111111, 6'b000000, 1'b0, 0, 0, 24'h01};
      vt[7]  = '{6'b101011, 6'b000000, 1'b0, 2, 1, 24'h0125};
      vt[8]  = '{6'b101000, 6'b000000, 1'b0, 0, 0, 24'h0125};
      vt[9]  = '{6'b001111, 6'b000000, 1'b0, 0, 0, 24'h0189};
      vt[10] = '{6'b001011, 6'b000000, 1'b0, 0, 0, 24'h0189};
      vt[11] = '{6'b000000, 6'b000010, 1'b0, 0, 0, 24'h0167};
      vt[12] = '{6'b000000, 6'b000001, 1'b0, 0, 0, 24'h01};
      vt[13] = '{6'b000100, 6'b000000, 1'b1, 0, 0, 24'h01A};
      vt[14] = '{6'b000010, 6'b000000, 1'b0, 0, 0, 24'h01B};
      vt[15] = '{6'b100100, 6'b000000, 1'b0, 0, 0, 24'h01234};

      @(negedge clk);
      #1;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_count", instr_count, 32'd0);
      chk("reset_outputs", 32'(act), 32'(outs_t'{mem_read: 1'b1, alu_src_b: 2'b01, alu_op: 4'b0100, default: '0}));
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         run_instr(vt[i].op, vt[i].fn, vt[i].z, vt[i].fs, vt[i].ms, seen);
         chk($sformatf("path_vec%0d", i), 32'(seen), 32'(vt[i].path));
      end

      // Asynchronous reset while a load is stalled in MEM_READ.
      @(negedge clk); mem_ready = 1'b1;
      @(negedge clk); mem_ready = 1'b0; op_code = 6'b100011; funct = 6'd0;
      @(negedge clk); mem_ready = 1'b0;
      @(negedge clk); mem_ready = 1'b0;
      #1;
      chk("pre_reset_state", 32'(state), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_state", 32'(state), 32'd0);
      chk("mid_reset_count", instr_count, 32'd0);
      chk("mid_reset_writes", {30'd0, mem_write, reg_write}, 32'd0);
      chk("mid_reset_illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      #1;
      chk("held_reset_state", 32'(state), 32'd0);
      rst_n = 1'b1;
      exp_cnt = 32'd0;

      for (int i = 0; i < 200; i++) begin
         rop = ops[$urandom_range(0, 21)];
         if ($urandom_range(0, 7) == 0) rop = r6();
         rfn = fns[$urandom_range(0, 11)];
         if ($urandom_range(0, 5) == 0) rfn = r6();
         run_instr(rop, rfn, r1(), $urandom_range(0, 3), $urandom_range(0, 3), seen);
      end

      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk("final_state", 32'(state), 32'd0);
      chk("final_count", instr_count, exp_cnt);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
